// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared types and helpers for the load/store unit.
// Contents: access-size encodings, FSM state type, doubleword byte count,
//           and the alignment helpers used by the request decoder.
package mem_lsu_pkg;

  localparam int DW_BYTES = 8;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } lsu_state_t;

  // Low byte-address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] size_mask(input logic [1:0] size);
    logic [2:0] m;
    case (size)
      SZ_B:    m = 3'b000;
      SZ_H:    m = 3'b001;
      SZ_W:    m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
    return (off & size_mask(size)) != 3'b000;
  endfunction

endpackage

// File: rtl/mem_lsu_lane.sv
// mem_lsu_lane: combinational lane logic for the load/store unit.
// Ports: dw (memory doubleword), offset (byte offset), size, uns (zero-extend),
//        wdata (right-aligned store data) -> load_val (extended), merged (store image).
module mem_lsu_lane
  import mem_lsu_pkg::*;
(
  input  logic [63:0] dw,
  input  logic [2:0]  offset,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [63:0] wdata,
  output logic [63:0] load_val,
  output logic [63:0] merged
);

  logic [5:0]  shamt;
  logic [63:0] lane;
  logic [63:0] mask;

  always_comb begin
    shamt    = {offset, 3'b000};
    lane     = dw >> shamt;
    mask     = '1;
    load_val = lane;
    case (size)
      SZ_B: begin
        mask     = 64'h0000_0000_0000_00FF;
        load_val = uns ? {56'd0, lane[7:0]} : {{56{lane[7]}}, lane[7:0]};
      end
      SZ_H: begin
        mask     = 64'h0000_0000_0000_FFFF;
        load_val = uns ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
      end
      SZ_W: begin
        mask     = 64'h0000_0000_FFFF_FFFF;
        load_val = uns ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
      end
      default: begin
        mask     = '1;
        load_val = lane;
      end
    endcase
    // Replace only the addressed bytes; the rest of the doubleword is kept.
    merged = (dw & ~(mask << shamt)) | ((wdata & mask) << shamt);
  end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit driving a 64-bit doubleword-organised data memory.
// Ports: req_* (execute-stage request, valid/ready), resp_* (completion pulse, data, error),
//        d_mem_we/d_mem_addr/d_mem_data (memory port; data bus driven only while writing).
// Option: MEM_LSU_MISALIGN_TRAP_EN -> misaligned requests get an error response, no access;
//         otherwise the address is force-aligned to the size and resp_err stays 0.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int d_addr_bits = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [1:0]             req_size,
  input  logic                   req_unsigned,
  input  logic [d_addr_bits-1:0] req_addr,
  input  logic [63:0]            req_wdata,
  output logic                   resp_valid,
  output logic [63:0]            resp_rdata,
  output logic                   resp_err,
  output logic                   d_mem_we,
  output logic [d_addr_bits-1:0] d_mem_addr,
  inout  wire  [63:0]            d_mem_data
);

  lsu_state_t  state;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [2:0]  off_q;
  // Holds store data from accept, then the merged image once the read returns.
  logic [63:0] wr_dat;

  logic [63:0] load_val;
  logic [63:0] merged;
  logic        misaligned;
  logic [2:0]  eff_off;

`ifdef MEM_LSU_MISALIGN_TRAP_EN
  assign misaligned = is_misaligned(req_size, req_addr[2:0]);
  assign eff_off    = req_addr[2:0];
`else
  assign misaligned = 1'b0;
  assign eff_off    = req_addr[2:0] & ~size_mask(req_size);
`endif

  // The bus is released whenever we are not writing so the memory can drive it.
  assign d_mem_data = d_mem_we ? wr_dat : 64'bz;

  mem_lsu_lane u_lane (
    .dw       (d_mem_data),
    .offset   (off_q),
    .size     (size_q),
    .uns      (uns_q),
    .wdata    (wr_dat),
    .load_val (load_val),
    .merged   (merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      d_mem_we   <= 1'b0;
      d_mem_addr <= '0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= SZ_B;
      off_q      <= '0;
      wr_dat     <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            we_q       <= req_we;
            uns_q      <= req_unsigned;
            size_q     <= req_size;
            off_q      <= eff_off;
            wr_dat     <= req_wdata;
            d_mem_addr <= {req_addr[d_addr_bits-1:3], 3'b000};
            resp_err   <= misaligned;
            req_ready  <= 1'b0;
            if (misaligned) begin
              resp_rdata <= '0;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else if (req_we && req_size == SZ_D) begin
              // Full doubleword store needs no read: write immediately.
              d_mem_we <= 1'b1;
              state    <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          state <= CAP;
        end
        CAP: begin
          if (we_q) begin
            wr_dat   <= merged;
            d_mem_we <= 1'b1;
            state    <= WR;
          end else begin
            resp_rdata <= load_val;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        WR: begin
          d_mem_we   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          d_mem_we  <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: randomized scoreboard bench for mem_lsu against a byte-array reference model.
// Ports: none (top-level bench); instantiates mem_lsu and a behavioural doubleword memory.
module tb_mem_lsu;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [63:0]   req_wdata;
  logic          resp_valid, resp_err;
  logic [63:0]   resp_rdata;
  logic          d_mem_we;
  logic [AW-1:0] d_mem_addr;
  wire  [63:0]   d_mem_data;

  always #5 clk = ~clk;

  mem_lsu #(.d_addr_bits(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .d_mem_we     (d_mem_we),
    .d_mem_addr   (d_mem_addr),
    .d_mem_data   (d_mem_data)
  );

  // Behavioural memory: read data appears the cycle after the address, write at the edge.
  logic [63:0] mem [8];
  logic [63:0] rd_q;
  logic        mem_clr;
  assign d_mem_data = d_mem_we ? 64'bz : rd_q;
  always @(posedge clk) begin
    rd_q <= mem[d_mem_addr[5:3]];
    if (mem_clr) begin
      for (int i = 0; i < 8; i++) mem[i] <= 64'd0;
    end else if (d_mem_we) begin
      mem[d_mem_addr[5:3]] <= d_mem_data;
    end
  end

  // Reference model and scoreboard state.
  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
    int          wrs;
  } exp_t;

  logic [7:0]  ref_b [64];
  logic [63:0] last_rdata;
  exp_t        exp_q [$];
  int          acc_q [$];
  int          wst_q [$];
  int          edge_no = 0;
  int          wr_cnt = 0;
  int          last_resp_edge = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  bit          gap_chk = 1'b0;
  bit          prev_hold = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: event did not occur within its bound", name);
  endtask

  // Plain byte-level model: n = 2**size bytes, little-endian, at the (aligned) address.
  task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [5:0] addr, input logic [63:0] wd);
    exp_t        e;
    int          n;
    int          a;
    logic [63:0] v;
    n     = 1 << sz;
    e.wrs = 0;
    e.err = 1'b0;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
    if ((int'(addr) % n) != 0) begin
      last_rdata = 64'd0;
      e.rdata = 64'd0;
      e.err   = 1'b1;
      e.lat   = 1;
      exp_q.push_back(e);
      return;
    end
`endif
    a = int'(addr) - (int'(addr) % n);
    if (we) begin
      for (int i = 0; i < n; i++) ref_b[a+i] = wd[8*i +: 8];
      e.wrs = 1;
      e.lat = (n == 8) ? 2 : 4;
    end else begin
      v = 64'd0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_b[a+i];
      if (!uns && n < 8 && v[8*n-1]) begin
        for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
      end
      last_rdata = v;
      e.lat = 3;
    end
    e.rdata = last_rdata;
    exp_q.push_back(e);
  endtask

  // Edge monitor: accept bookkeeping, write-pulse counting, back-to-back gap.
  always @(posedge clk) begin
    edge_no++;
    if (d_mem_we) wr_cnt++;
    if (!rst && req_valid && req_ready) begin
      if (gap_chk) chk("b2b_accept_edge", 64'(edge_no), 64'(last_resp_edge + 2));
      acc_q.push_back(edge_no);
      wst_q.push_back(wr_cnt);
    end
  end

  // Response monitor: pops the scoreboard whenever the DUT signals completion.
  always @(negedge clk) begin : resp_mon
    exp_t e;
    int   a;
    int   w;
    if (!rst && resp_valid) begin
      if (exp_q.size() == 0 || acc_q.size() == 0) begin
        fail_now("unexpected_resp");
      end else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        w = wst_q.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", 64'(resp_err), 64'(e.err));
        chk("latency", 64'(edge_no - a + 1), 64'(e.lat));
        chk("write_pulses", 64'(wr_cnt - w), 64'(e.wrs));
      end
      last_resp_edge = edge_no;
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [5:0] addr, input logic [63:0] wd,
                       input bit hold, input bit do_model);
    int t = 0;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    gap_chk      = prev_hold;
    @(posedge clk);
    while (!req_ready && t < 40) begin
      @(posedge clk);
      t++;
    end
    if (t >= 40) fail_now("accept_timeout");
    else if (do_model) model(we, sz, uns, addr, wd);
    @(negedge clk);
    gap_chk = 1'b0;
    if (!hold) req_valid = 1'b0;
    prev_hold = hold;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while ((!req_ready || exp_q.size() != 0) && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) fail_now("idle_timeout");
  endtask

  initial begin : watchdog
    #400000;
    fail_now("global_timeout");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : stim
    int wr_before;
    logic [63:0] w64;
    bit h;
    rst = 1'b1;
    mem_clr = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_size = 2'b00;
    req_unsigned = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    last_rdata = 64'd0;
    for (int i = 0; i < 64; i++) ref_b[i] = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_d_mem_we", 64'(d_mem_we), 64'd0);
    chk("rst_d_mem_addr", 64'(d_mem_addr), 64'd0);
    chk("rst_bus_released", d_mem_data, 64'd0);
    mem_clr = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Directed sequence.
    issue(1'b1, 2'b11, 1'b0, 6'h08, 64'h1122334455667788, 1'b0, 1'b1); wait_idle();
    issue(1'b0, 2'b11, 1'b0, 6'h08, 64'd0, 1'b0, 1'b1); wait_idle();
    issue(1'b1, 2'b00, 1'b0, 6'h0B, 64'h00000000000000AB, 1'b0, 1'b1); wait_idle();
    chk("byte_rmw_mem", mem[1], 64'h11223344AB667788);
    issue(1'b0, 2'b11, 1'b0, 6'h08, 64'd0, 1'b0, 1'b1); wait_idle();
    issue(1'b0, 2'b00, 1'b0, 6'h0B, 64'd0, 1'b0, 1'b1); wait_idle();
    issue(1'b0, 2'b00, 1'b1, 6'h0B, 64'd0, 1'b0, 1'b1); wait_idle();
    issue(1'b0, 2'b10, 1'b0, 6'h0C, 64'd0, 1'b0, 1'b1); wait_idle();
    issue(1'b1, 2'b11, 1'b0, 6'h00, 64'hA1B2C3D4E5F60718, 1'b0, 1'b1); wait_idle();
    issue(1'b0, 2'b01, 1'b0, 6'h03, 64'd0, 1'b0, 1'b1); wait_idle();
    issue(1'b1, 2'b01, 1'b0, 6'h05, 64'h000000000000BEEF, 1'b0, 1'b1); wait_idle();

    // Reset during CAP of a byte store: no write, unit idle again.
    wr_before = wr_cnt;
    w64 = mem[2];
    issue(1'b1, 2'b00, 1'b0, 6'h13, 64'h00000000000000CD, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_we", 64'(d_mem_we), 64'd0);
    chk("midrst_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    acc_q.delete();
    wst_q.delete();
    last_rdata = 64'd0;
    @(negedge clk);
    chk("postrst_ready", 64'(req_ready), 64'd1);
    chk("postrst_rdata", resp_rdata, 64'd0);
    chk("postrst_no_write", 64'(wr_cnt - wr_before), 64'd0);
    chk("postrst_mem", mem[2], w64);

    // Random traffic, mixing back-to-back (valid held) and spaced requests.
    for (int k = 0; k < 150; k++) begin
      h = (k != 149) && ($urandom_range(0, 1) == 1);
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            6'($urandom_range(0, 63)), {$urandom, $urandom}, h, 1'b1);
      if (!h) wait_idle();
    end
    wait_idle();

    // Memory image against the model.
    for (int d = 0; d < 8; d++) begin
      w64 = 64'd0;
      for (int i = 0; i < 8; i++) w64[8*i +: 8] = ref_b[8*d+i];
      chk("final_mem", mem[d], w64);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
